cond_unit_it: RTL and testbench

Parametrised conditional-execution unit for the ARM-subset core. It holds banked NZCV flag registers and evaluates the 4-bit condition field against the selected bank. It gates the RegWrite, MemWrite and PCSrc controls, and supports IT-style predicated blocks of up to MAX_IT following instructions. It sits between the decoder/control unit and the register file, memory and PC-select logic.

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_eval.sv | 42 ++++
 rtl/cond_unit_it.sv | 197 +++++++++++++++++++
 tb/tb_cond_unit_it.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// NZCV bit positions inside a flag nibble, and the IT-block state encoding.
package cond_pkg;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // IT block tracking state
  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: decides whether a 4-bit condition
// passes against one NZCV nibble. NV (1111) is a defined never-pass.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  // Decode the condition field against the selected flags
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: banked NZCV flags, condition gating of the
// RegWrite / MemWrite / PCSrc controls, and optional IT-style predicated
// blocks. The IT machinery is built only when COND_IT_EN is defined;
// otherwise every instruction is evaluated on its own cond field.
module cond_unit_it
  import cond_pkg::*;
#(
  parameter int NUM_BANKS = 1,
  parameter int MAX_IT    = 4,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int LEN_W     = $clog2(MAX_IT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond,
  input  logic [1:0]        flag_w,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              pcs,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic [3:0]        alu_flags,
  input  logic              it_start,
  input  logic [3:0]        it_cond,
  input  logic [MAX_IT-1:0] it_mask,
  input  logic [LEN_W-1:0]  it_len,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic              cond_ex,
  output logic [3:0]        flags_out,
  output logic              it_active,
  output logic              it_err
);

  logic [3:0] flags_q [NUM_BANKS];
  logic [3:0] flags_d [NUM_BANKS];
  logic [3:0] bank_flags;
  logic [3:0] eff_cond;
  logic       it_suppress;
  logic       acc;
  logic       pass;

  assign acc = instr_valid & ~stall & ~flush;

  // Read the registered flags of the addressed bank (out-of-range reads give 0)
  always_comb begin
    bank_flags = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(bank_sel) == b) bank_flags = flags_q[b];
    end
  end

  cond_eval u_eval (
    .cond_i (eff_cond),
    .nzcv_i (bank_flags),
    .pass_o (pass)
  );

  // An IT instruction (legal or nested) never writes anything itself
  assign cond_ex   = acc & pass & ~it_suppress;
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;
  assign flags_out = bank_flags;

  // Next flag state: only the executing instruction's bank and selected pairs change
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      flags_d[b] = flags_q[b];
      if (cond_ex && (int'(bank_sel) == b)) begin
        if (flag_w[1]) begin
          flags_d[b][FLAG_N] = alu_flags[FLAG_N];
          flags_d[b][FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_w[0]) begin
          flags_d[b][FLAG_C] = alu_flags[FLAG_C];
          flags_d[b][FLAG_V] = alu_flags[FLAG_V];
        end
      end
    end
  end

  // Flag bank registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the flag banks are architecturally visible state, so every entry is cleared on reset.
      for (int b = 0; b < NUM_BANKS; b++) flags_q[b] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
      flags_q <= flags_d;
    end
  end

`ifdef COND_IT_EN
  it_state_e             state_q, state_d;
  logic [LEN_W-1:0]      slot_q, slot_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [3:0]            it_cond_q, it_cond_d;
  logic [MAX_IT-1:0]     mask_q, mask_d;
  logic                  it_err_q, it_err_d;
  logic                  mask_bit;
  logic                  len_ok;
  logic                  last_slot;

  assign len_ok    = (it_len != '0) && (int'(it_len) <= MAX_IT);
  assign last_slot = (slot_q == len_q - 1'b1);

  // Pick the mask bit of the current slot without an over-wide index
  always_comb begin
    mask_bit = 1'b0;
    for (int i = 0; i < MAX_IT; i++) begin
      if (int'(slot_q) == i) mask_bit = mask_q[i];
    end
  end

  // Inside a block the slot condition replaces cond; inverting AL yields NV
  assign eff_cond    = (state_q == IT_ACTIVE)
                     ? (mask_bit ? it_cond_q : {it_cond_q[3:1], ~it_cond_q[0]})
                     : cond;
  assign it_suppress = it_start;

  // IT block sequencing: start, slot advance, early termination, error pulse
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    len_d     = len_q;
    it_cond_d = it_cond_q;
    mask_d    = mask_q;
    it_err_d  = 1'b0;
    if (!stall) begin
      case (state_q)
        IT_IDLE: begin
          if (acc && it_start) begin
            if (len_ok) begin
              state_d   = IT_ACTIVE;
              slot_d    = '0;
              len_d     = it_len;
              it_cond_d = it_cond;
              mask_d    = it_mask;
            end else begin
              it_err_d = 1'b1;
            end
          end
        end
        IT_ACTIVE: begin
          if (flush) begin
            state_d = IT_IDLE;
            slot_d  = '0;
          end else if (acc) begin
            if (it_start) it_err_d = 1'b1;
            slot_d = slot_q + 1'b1;
            if (pc_src || last_slot) begin
              state_d = IT_IDLE;
              slot_d  = '0;
            end
          end
        end
        default: state_d = IT_IDLE;
      endcase
    end
  end

  // IT state, latched block parameters and registered error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IT_IDLE;
      slot_q    <= '0;
      len_q     <= '0;
      it_cond_q <= '0;
      mask_q    <= '0;
      it_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      len_q     <= len_d;
      it_cond_q <= it_cond_d;
      mask_q    <= mask_d;
      it_err_q  <= it_err_d;
    end
  end

  assign it_active = (state_q == IT_ACTIVE);
  assign it_err    = it_err_q;
`else
  logic unused_it;

  assign unused_it   = ^{it_start, it_cond, it_mask, it_len};
  assign eff_cond    = cond;
  assign it_suppress = 1'b0;
  assign it_active   = 1'b0;
  assign it_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit_it.sv
// Self-checking bench for cond_unit_it (two flag banks, MAX_IT = 4).
// Expectations follow COND_IT_EN: with it defined the IT sequences are
// checked, otherwise it_start instructions must execute normally.
module tb_cond_unit_it;

  localparam int NB = 2;
  localparam int MI = 4;
  localparam int LW = 3;
`ifdef COND_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif

  logic          clk, reset;
  logic          instr_valid, stall, flush;
  logic [3:0]    cond;
  logic [1:0]    flag_w;
  logic          bank_sel;
  logic          pcs, reg_w, mem_w;
  logic [3:0]    alu_flags;
  logic          it_start;
  logic [3:0]    it_cond;
  logic [MI-1:0] it_mask;
  logic [LW-1:0] it_len;
  logic          pc_src, reg_write, mem_write, cond_ex;
  logic [3:0]    flags_out;
  logic          it_active, it_err;

  int n_checks = 0;
  int n_errors = 0;

  cond_unit_it #(.NUM_BANKS(NB), .MAX_IT(MI)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
    .flush(flush), .cond(cond), .flag_w(flag_w), .bank_sel(bank_sel),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .alu_flags(alu_flags),
    .it_start(it_start), .it_cond(it_cond), .it_mask(it_mask), .it_len(it_len),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .cond_ex(cond_ex), .flags_out(flags_out), .it_active(it_active), .it_err(it_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    instr_valid = 0; stall = 0; flush = 0; cond = 4'hE; flag_w = 0; bank_sel = 0;
    pcs = 0; reg_w = 0; mem_w = 0; alu_flags = 0;
    it_start = 0; it_cond = 0; it_mask = 0; it_len = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  task automatic it_go(input logic [3:0] c, input logic [MI-1:0] m, input logic [LW-1:0] l);
    nxt();
    instr_valid = 1; it_start = 1; it_cond = c; it_mask = m; it_len = l;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       valid, stl, fl;
    logic [3:0] c;
    logic [1:0] fw;
    logic       bank, p, r, m;
    logic [3:0] alu;
    logic [3:0] e_ctrl;   // {pc_src, reg_write, mem_write, cond_ex}
    logic [3:0] e_flags;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic v, s, f, input logic [3:0] c, input logic [1:0] fw,
                     input logic b, p, r, m, input logic [3:0] a,
                     input logic [3:0] ec, input logic [3:0] ef);
    vec_t t;
    t = '{v, s, f, c, fw, b, p, r, m, a, ec, ef};
    vecs.push_back(t);
  endtask

  // ---------------- reference model ----------------
  logic [3:0]    mf [NB];
  bit            m_act, m_err;
  int            m_slot, m_len;
  logic [3:0]    m_icond;
  logic [MI-1:0] m_mask;

  // Pairs of codes share a predicate; the odd member is its complement
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      default: base = !f[2] && (f[3] == f[0]);
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) mf[b] = 4'h0;
    m_act = 0; m_err = 0; m_slot = 0; m_len = 0; m_icond = 0; m_mask = 0;
  endtask

  task automatic run_random(input int cycles);
    logic acc, its, pass, cex;
    logic [3:0] effc;
    bit n_err;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(99) < 85);
      stall       = ($urandom_range(99) < 10);
      flush       = ($urandom_range(99) < 5);
      cond        = 4'($urandom);
      flag_w      = 2'($urandom);
      bank_sel    = 1'($urandom);
      pcs         = ($urandom_range(99) < 15);
      reg_w       = 1'($urandom);
      mem_w       = 1'($urandom);
      alu_flags   = 4'($urandom);
      it_start    = ($urandom_range(99) < 10);
      it_cond     = 4'($urandom);
      it_mask     = MI'($urandom);
      it_len      = LW'($urandom_range(5, 0));
      #1;
      acc  = instr_valid && !stall && !flush;
      its  = IT_EN && it_start;
      effc = (IT_EN && m_act) ? (m_mask[m_slot] ? m_icond : (m_icond ^ 4'h1)) : cond;
      pass = ref_pass(effc, mf[bank_sel]);
      cex  = acc && pass && !its;
      check("rnd_ctrl", 8'({pc_src, reg_write, mem_write, cond_ex}),
            8'({pcs && cex, reg_w && cex, mem_w && cex, cex}));
      check("rnd_flags", 8'(flags_out), 8'(mf[bank_sel]));
      check("rnd_it", 8'({it_active, it_err}), 8'({m_act, m_err}));
      if (cex) begin
        if (flag_w[1]) mf[bank_sel][3:2] = alu_flags[3:2];
        if (flag_w[0]) mf[bank_sel][1:0] = alu_flags[1:0];
      end
      n_err = 0;
      if (IT_EN && !stall) begin
        if (m_act) begin
          if (flush) m_act = 0;
          else if (acc) begin
            if (its) n_err = 1;
            m_slot++;
            if (m_slot == m_len || (pcs && cex)) m_act = 0;
          end
        end else if (acc && its) begin
          if (it_len >= 1 && int'(it_len) <= MI) begin
            m_act = 1; m_slot = 0; m_len = int'(it_len); m_icond = it_cond; m_mask = it_mask;
          end else n_err = 1;
        end
      end
      m_err = n_err;
    end
  endtask

  initial begin
    clr();
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_flags", 8'(flags_out), 8'h0);
    check("rst_it", 8'({it_active, it_err}), 8'h0);
    check("rst_cex", 8'({pc_src, reg_write, mem_write, cond_ex}), 8'h0);
    reset = 0;

    //   v s f cond  fw  bk p r m alu    {pc,rw,mw,cex} flags
    add(1,0,0,4'h0,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h0); // EQ with Z=0 fails
    add(1,0,0,4'hE,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h0); // AL
    add(1,0,0,4'hF,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h0); // NV
    add(1,0,0,4'hE,2'b10,1,0,0,1,4'h4, 4'b0011, 4'h0); // bank1 Z=1
    add(1,0,0,4'h0,2'b00,1,0,1,0,4'h0, 4'b0101, 4'h4); // bank1 EQ passes
    add(1,0,0,4'h0,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h0); // bank0 EQ fails
    add(1,0,0,4'hE,2'b10,0,0,0,0,4'h4, 4'b0001, 4'h0); // bank0 NZ <- 01
    add(1,0,0,4'h0,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h4); // EQ now passes
    add(1,0,0,4'hE,2'b01,0,0,0,0,4'h3, 4'b0001, 4'h4); // CV <- 11 only
    add(1,0,0,4'h8,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h7); // HI fails
    add(1,0,0,4'h9,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h7); // LS passes
    add(1,0,0,4'hA,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h7); // GE fails
    add(1,0,0,4'hB,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h7); // LT passes
    add(1,0,0,4'hC,2'b00,0,0,1,0,4'h0, 4'b0000, 4'h7); // GT fails
    add(1,0,0,4'hD,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h7); // LE passes
    add(1,0,0,4'h1,2'b11,0,0,0,0,4'h8, 4'b0000, 4'h7); // NE fails, no write
    add(1,0,0,4'hE,2'b00,0,1,0,0,4'h0, 4'b1001, 4'h7); // branch taken
    add(0,0,0,4'hE,2'b11,0,0,1,0,4'hF, 4'b0000, 4'h7); // invalid
    add(1,0,0,4'hE,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h7);
    add(1,0,0,4'h4,2'b00,1,0,1,0,4'h0, 4'b0000, 4'h4); // bank1 MI fails
    add(1,1,0,4'hE,2'b11,0,0,1,0,4'hF, 4'b0000, 4'h7); // stall
    add(1,0,1,4'hE,2'b11,0,0,1,0,4'hF, 4'b0000, 4'h7); // flush
    add(1,0,0,4'hE,2'b00,0,0,1,0,4'h0, 4'b0101, 4'h7); // flags held

    for (int i = 0; i < vecs.size(); i++) begin
      nxt();
      instr_valid = vecs[i].valid; stall = vecs[i].stl; flush = vecs[i].fl;
      cond = vecs[i].c; flag_w = vecs[i].fw; bank_sel = vecs[i].bank;
      pcs = vecs[i].p; reg_w = vecs[i].r; mem_w = vecs[i].m; alu_flags = vecs[i].alu;
      #1;
      check($sformatf("vec%0d_ctrl", i), 8'({pc_src, reg_write, mem_write, cond_ex}), 8'(vecs[i].e_ctrl));
      check($sformatf("vec%0d_flags", i), 8'(flags_out), 8'(vecs[i].e_flags));
    end

`ifdef COND_IT_EN
    // IT EQ, mask 101, len 3 with Z=1 on bank 0
    it_go(4'h0, 4'b0101, 3'd3); reg_w = 1; #1;
    check("it_instr_rw", 8'(reg_write), 8'h0);
    check("it_instr_act", 8'(it_active), 8'h0);
    nxt(); instr_valid = 1; cond = 4'hF; reg_w = 1; #1;
    check("it_slot0", 8'({it_active, reg_write}), 8'h3);
    nxt(); reg_w = 1; #1;
    check("it_bubble", 8'({it_active, reg_write}), 8'h2);
    nxt(); instr_valid = 1; reg_w = 1; #1;
    check("it_slot1", 8'({it_active, reg_write}), 8'h2);
    nxt(); instr_valid = 1; reg_w = 1; #1;
    check("it_slot2", 8'({it_active, reg_write}), 8'h3);
    nxt(); instr_valid = 1; cond = 4'h1; reg_w = 1; #1;
    check("it_done", 8'({it_active, reg_write}), 8'h0);

    // flush on slot 1 aborts without flag update
    it_go(4'hE, 4'b1111, 3'd4);
    nxt(); instr_valid = 1; reg_w = 1; #1;
    check("fl_slot0", 8'(reg_write), 8'h1);
    nxt(); instr_valid = 1; flush = 1; flag_w = 2'b11; alu_flags = 4'h0; reg_w = 1; #1;
    check("fl_slot1", 8'({it_active, reg_write}), 8'h2);
    nxt(); #1;
    check("fl_idle", 8'(it_active), 8'h0);
    check("fl_flags", 8'(flags_out), 8'h7);

    // taken branch in slot 0 ends the block
    it_go(4'hE, 4'b1111, 3'd4);
    nxt(); instr_valid = 1; pcs = 1; #1;
    check("br_slot0", 8'(pc_src), 8'h1);
    nxt(); #1;
    check("br_idle", 8'(it_active), 8'h0);

    // illegal lengths
    it_go(4'hE, 4'b1111, 3'd0); reg_w = 1; #1;
    check("len0_cex", 8'(cond_ex), 8'h0);
    nxt(); #1;
    check("len0_err", 8'({it_active, it_err}), 8'h1);
    nxt(); #1;
    check("len0_err_drop", 8'(it_err), 8'h0);
    it_go(4'hE, 4'b1111, 3'd5);
    nxt(); #1;
    check("len5_err", 8'({it_active, it_err}), 8'h1);

    // nested IT inside a block
    it_go(4'hE, 4'b0111, 3'd3);
    nxt(); instr_valid = 1; it_start = 1; it_len = 3'd2; reg_w = 1; mem_w = 1; #1;
    check("nest_nowrite", 8'({reg_write, mem_write, cond_ex}), 8'h0);
    nxt(); instr_valid = 1; reg_w = 1; #1;
    check("nest_err", 8'({it_active, it_err, reg_write}), 8'h7);
    nxt(); instr_valid = 1; reg_w = 1; #1;
    check("nest_slot2", 8'({it_active, it_err, reg_write}), 8'h5);
    nxt(); #1;
    check("nest_done", 8'(it_active), 8'h0);

    // asynchronous reset mid-block
    it_go(4'hE, 4'b1111, 3'd4);
    nxt(); #1;
    check("pre_rst", 8'({it_active, flags_out}), 8'h17);
`else
    // IT fields are ignored: it_start executes as a normal instruction
    nxt(); instr_valid = 1; it_start = 1; it_len = 3'd0; cond = 4'hE; reg_w = 1; #1;
    check("noit_exec", 8'(reg_write), 8'h1);
    nxt(); instr_valid = 1; it_start = 1; it_cond = 4'hE; it_mask = 4'hF; it_len = 3'd3;
    cond = 4'hF; reg_w = 1; #1;
    check("noit_cond", 8'(reg_write), 8'h0);
    nxt(); instr_valid = 1; cond = 4'h1; reg_w = 1; #1;
    check("noit_idle", 8'({it_active, it_err, reg_write}), 8'h0);
    nxt(); #1;
    check("pre_rst", 8'(flags_out), 8'h7);
`endif
    #1 reset = 1;
    #1;
    check("rst_async_act", 8'(it_active), 8'h0);
    check("rst_async_flags", 8'(flags_out), 8'h0);
    @(negedge clk);
    reset = 0;

    model_reset();
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
